// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between two requester ports.
// Each port posts one-cycle load/store pulses into a one-deep pending slot.
// A three-state FSM (IDLE -> ISSUE -> WAIT) keeps at most one memory access
// in flight and answers the owning port with a one-cycle done pulse. It
// aborts an access that waits MAX_WAIT cycles without a memory response.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req0_read_i,
    input  logic        req0_write_i,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_data_i,
    output logic        req0_done_o,
    output logic [31:0] req0_rd_data_o,
    input  logic        req1_read_i,
    input  logic        req1_write_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_data_i,
    output logic        req1_done_o,
    output logic [31:0] req1_rd_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_rd_data_i,
    input  logic        mem_done_i,
    output logic        grant_o,
    output logic        busy_o,
    output logic        overflow_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_q, rr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       overflow_q, overflow_d;
    logic       timeout_q, timeout_d;

    // Per-port request inputs gathered into vectors indexed by port number.
    logic [1:0]        rd_pulse, wr_pulse, any_pulse;
    logic [1:0][31:0]  addr_in, data_in;

    // Pending slot per port; op = 1 marks a store.
    logic [1:0]        pend_valid_q, pend_valid_d;
    logic [1:0]        pend_op_q, pend_op_d;
    logic [1:0][31:0]  pend_addr_q, pend_addr_d;
    logic [1:0][31:0]  pend_data_q, pend_data_d;

    logic [1:0]        take, drop, done_vec;
    logic              finish, abort;
    logic [31:0]       load_data;

    assign rd_pulse = {req1_read_i, req0_read_i};
    assign wr_pulse = {req1_write_i, req0_write_i};
    assign addr_in  = {req1_addr_i, req0_addr_i};
    assign data_in  = {req1_data_i, req0_data_i};

    // A slot accepts a pulse when empty, or when its current access is being
    // answered this very cycle (so a requester can chain back-to-back).
    // Otherwise the pulse is lost and flagged as overflow.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign any_pulse[gi]    = rd_pulse[gi] | wr_pulse[gi];
            assign take[gi]         = any_pulse[gi] & (~pend_valid_q[gi] | done_vec[gi]);
            assign drop[gi]         = any_pulse[gi] & pend_valid_q[gi] & ~done_vec[gi];
            assign pend_valid_d[gi] = take[gi] | (pend_valid_q[gi] & ~done_vec[gi]);
            // Store wins when load and store pulse together.
            assign pend_op_d[gi]    = take[gi] ? wr_pulse[gi] : pend_op_q[gi];
            assign pend_addr_d[gi]  = take[gi] ? addr_in[gi] : pend_addr_q[gi];
            assign pend_data_d[gi]  = take[gi] ? data_in[gi] : pend_data_q[gi];
        end
    endgenerate

    // Pending slot registers for both ports.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_valid_q <= '0;
            pend_op_q    <= '0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

    // FSM, grant, round-robin pointer, wait counter and sticky flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            rr_q       <= 1'b0;
            cnt_q      <= 8'd0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, strobe for one cycle in ISSUE,
    // then wait for the response or give up after MAX_WAIT cycles.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q | (|drop);
        finish     = 1'b0;
        abort      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pend_valid_q) begin
                    // Both waiting: round-robin pointer decides; else the lone one.
                    grant_d = (&pend_valid_q) ? rr_q : pend_valid_q[1];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done_i) begin
                    finish  = 1'b1;
                    rr_d    = ~grant_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == MAX_WAIT_C) begin
                        abort     = 1'b1;
                        timeout_d = 1'b1;
                        rr_d      = ~grant_q;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign done_vec  = {(finish | abort) & grant_q, (finish | abort) & ~grant_q};
    assign load_data = (finish && !pend_op_q[grant_q]) ? mem_rd_data_i : 32'd0;

    // Memory-side strobes and buses are live only during the ISSUE cycle.
    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = 32'd0;
        mem_data_o  = 32'd0;
        if (state_q == ST_ISSUE) begin
            mem_read_o  = ~pend_op_q[grant_q];
            mem_write_o = pend_op_q[grant_q];
            mem_addr_o  = pend_addr_q[grant_q];
            mem_data_o  = pend_data_q[grant_q];
        end
    end

    assign req0_done_o    = done_vec[0];
    assign req1_done_o    = done_vec[1];
    assign req0_rd_data_o = done_vec[0] ? load_data : 32'd0;
    assign req1_rd_data_o = done_vec[1] ? load_data : 32'd0;
    assign grant_o        = grant_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign overflow_o     = overflow_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios for latency, arbitration,
// overflow, timeout and reset behaviour. A randomized run is then checked
// against a timestamp-based reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req0_read_i, req0_write_i, req1_read_i, req1_write_i;
    logic [31:0] req0_addr_i, req0_data_i, req1_addr_i, req1_data_i;
    logic        req0_done_o, req1_done_o;
    logic [31:0] req0_rd_data_o, req1_rd_data_o;
    logic        mem_read_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_done_i;
    logic        grant_o, busy_o, overflow_o, timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req0_read_i    (req0_read_i),
        .req0_write_i   (req0_write_i),
        .req0_addr_i    (req0_addr_i),
        .req0_data_i    (req0_data_i),
        .req0_done_o    (req0_done_o),
        .req0_rd_data_o (req0_rd_data_o),
        .req1_read_i    (req1_read_i),
        .req1_write_i   (req1_write_i),
        .req1_addr_i    (req1_addr_i),
        .req1_data_i    (req1_data_i),
        .req1_done_o    (req1_done_o),
        .req1_rd_data_o (req1_rd_data_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_rd_data_i  (mem_rd_data_i),
        .mem_done_i     (mem_done_i),
        .grant_o        (grant_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        req0_read_i   = 1'b0;
        req0_write_i  = 1'b0;
        req1_read_i   = 1'b0;
        req1_write_i  = 1'b0;
        req0_addr_i   = 32'd0;
        req0_data_i   = 32'd0;
        req1_addr_i   = 32'd0;
        req1_data_i   = 32'd0;
        mem_done_i    = 1'b0;
        mem_rd_data_i = 32'd0;
    endtask

    // Start a new cycle: move to the falling edge and drop all pulses.
    task automatic begin_cycle();
        @(negedge clk_i);
        req0_read_i  = 1'b0;
        req0_write_i = 1'b0;
        req1_read_i  = 1'b0;
        req1_write_i = 1'b0;
        mem_done_i   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        clear_inputs();
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        clear_inputs();
        @(negedge clk_i);
        #1;
        n_checks++;
        if ({req0_done_o, req1_done_o, mem_read_o, mem_write_o, grant_o, busy_o, overflow_o, timeout_o} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {req0_done_o, req1_done_o, mem_read_o, mem_write_o, grant_o, busy_o, overflow_o, timeout_o});
        end
        n_checks++;
        if ({mem_addr_o, mem_data_o, req0_rd_data_o, req1_rd_data_o} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_buses: got %h want 0", {mem_addr_o, mem_data_o, req0_rd_data_o, req1_rd_data_o});
        end
        reset_i = 1'b0;
        begin_cycle();
        #1;
        n_checks++;
        if ({busy_o, grant_o, overflow_o, timeout_o} !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_status: got %b want 0000", {busy_o, grant_o, overflow_o, timeout_o});
        end
    endtask

    task automatic test_single_read();
        begin_cycle();
        req0_read_i = 1'b1;
        req0_addr_i = 32'h0000_0100;
        #1;
        begin_cycle();
        #1;
        n_checks++;
        if ({busy_o, mem_read_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_t1_idle: busy/read got %b want 00", {busy_o, mem_read_o});
        end
        begin_cycle();
        #1;
        n_checks++;
        if ({mem_read_o, mem_write_o, busy_o, grant_o, mem_addr_o} !== {4'b1010, 32'h0000_0100}) begin
            n_fail++;
            $display("FAIL single_t2_strobe: rd/wr/busy/grant/addr got %b %h want 1010 00000100",
                     {mem_read_o, mem_write_o, busy_o, grant_o}, mem_addr_o);
        end
        begin_cycle();
        #1;
        n_checks++;
        if ({mem_read_o, mem_addr_o, req0_done_o} !== 34'd0) begin
            n_fail++;
            $display("FAIL single_t3_quiet: read=%b addr=%h done=%b want 0 0 0", mem_read_o, mem_addr_o, req0_done_o);
        end
        begin_cycle();
        mem_done_i    = 1'b1;
        mem_rd_data_i = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({req0_done_o, req1_done_o, req0_rd_data_o} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL single_t4_done: done0=%b done1=%b data=%h want 1 0 deadbeef",
                     req0_done_o, req1_done_o, req0_rd_data_o);
        end
        $display("txn port=0 load addr=00000100 data=%h", req0_rd_data_o);
        begin_cycle();
        #1;
        n_checks++;
        if ({req0_done_o, busy_o, req0_rd_data_o} !== 34'd0) begin
            n_fail++;
            $display("FAIL single_t5_after: done=%b busy=%b data=%h want 0 0 0", req0_done_o, busy_o, req0_rd_data_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int round = 0; round < 2; round++) begin
            logic [31:0] a0, a1, d0, d1;
            a0 = 32'h1000 + 32'(round * 16);
            a1 = 32'h2000 + 32'(round * 16);
            d0 = $urandom();
            d1 = $urandom();
            begin_cycle();
            req0_write_i = 1'b1; req0_addr_i = a0; req0_data_i = d0;
            req1_write_i = 1'b1; req1_addr_i = a1; req1_data_i = d1;
            #1;
            begin_cycle();
            #1;
            begin_cycle();
            #1;
            n_checks++;
            if ({mem_write_o, mem_read_o, grant_o, mem_addr_o, mem_data_o} !== {3'b100, a0, d0}) begin
                n_fail++;
                $display("FAIL simul_first_port0 r%0d: wr/rd/grant=%b addr=%h data=%h want 100 %h %h",
                         round, {mem_write_o, mem_read_o, grant_o}, mem_addr_o, mem_data_o, a0, d0);
            end
            begin_cycle();
            mem_done_i    = 1'b1;
            mem_rd_data_i = $urandom();
            #1;
            n_checks++;
            if ({req0_done_o, req1_done_o, req0_rd_data_o} !== {2'b10, 32'd0}) begin
                n_fail++;
                $display("FAIL simul_done0 r%0d: done0=%b done1=%b data=%h want 1 0 0",
                         round, req0_done_o, req1_done_o, req0_rd_data_o);
            end
            $display("txn port=0 store addr=%h data=%h", a0, d0);
            begin_cycle();
            #1;
            n_checks++;
            if ({mem_write_o, mem_read_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL simul_gap r%0d: strobe got %b want 00 one cycle after done", round, {mem_write_o, mem_read_o});
            end
            begin_cycle();
            #1;
            n_checks++;
            if ({mem_write_o, grant_o, mem_addr_o, mem_data_o} !== {2'b11, a1, d1}) begin
                n_fail++;
                $display("FAIL simul_second_port1 r%0d: wr/grant=%b addr=%h data=%h want 11 %h %h",
                         round, {mem_write_o, grant_o}, mem_addr_o, mem_data_o, a1, d1);
            end
            begin_cycle();
            mem_done_i = 1'b1;
            #1;
            n_checks++;
            if ({req1_done_o, req0_done_o} !== 2'b10) begin
                n_fail++;
                $display("FAIL simul_done1 r%0d: done1/done0 got %b want 10", round, {req1_done_o, req0_done_o});
            end
            $display("txn port=1 store addr=%h data=%h", a1, d1);
        end
    endtask

    task automatic test_overflow();
        int strobes;
        do_reset();
        begin_cycle();
        req1_read_i = 1'b1; req1_addr_i = 32'h0000_0A00; req1_data_i = 32'h1;
        #1;
        begin_cycle();
        req1_write_i = 1'b1; req1_addr_i = 32'h0000_0B00;
        #1;
        n_checks++;
        if (overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_early: overflow got %b want 0", overflow_o);
        end
        begin_cycle();
        #1;
        n_checks++;
        if ({overflow_o, mem_read_o, mem_write_o, mem_addr_o} !== {3'b110, 32'h0000_0A00}) begin
            n_fail++;
            $display("FAIL ovf_drop: ovf/rd/wr=%b addr=%h want 110 00000a00", {overflow_o, mem_read_o, mem_write_o}, mem_addr_o);
        end
        begin_cycle();
        #1;
        begin_cycle();
        mem_done_i    = 1'b1;
        mem_rd_data_i = 32'h5555_AAAA;
        #1;
        n_checks++;
        if ({req1_done_o, req1_rd_data_o} !== {1'b1, 32'h5555_AAAA}) begin
            n_fail++;
            $display("FAIL ovf_done: done1=%b data=%h want 1 5555aaaa", req1_done_o, req1_rd_data_o);
        end
        $display("txn port=1 load addr=00000a00 data=%h", req1_rd_data_o);
        strobes = 0;
        repeat (6) begin
            begin_cycle();
            #1;
            strobes += int'(mem_read_o) + int'(mem_write_o);
        end
        n_checks++;
        if (strobes != 0 || overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_no_extra: strobes=%0d overflow=%b want 0 1", strobes, overflow_o);
        end
        // A pulse arriving in the same cycle as that port's done is kept.
        do_reset();
        begin_cycle();
        req0_read_i = 1'b1; req0_addr_i = 32'h0000_0C00;
        #1;
        begin_cycle(); #1;
        begin_cycle(); #1;
        begin_cycle();
        mem_done_i   = 1'b1;
        req0_write_i = 1'b1; req0_addr_i = 32'h0000_0D00; req0_data_i = 32'h77;
        #1;
        n_checks++;
        if (req0_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL chain_done: done0 got %b want 1", req0_done_o);
        end
        $display("txn port=0 load addr=00000c00 data=%h", req0_rd_data_o);
        begin_cycle(); #1;
        begin_cycle(); #1;
        n_checks++;
        if ({mem_write_o, overflow_o, mem_addr_o, mem_data_o} !== {2'b10, 32'h0000_0D00, 32'h77}) begin
            n_fail++;
            $display("FAIL chain_accept: wr/ovf=%b addr=%h data=%h want 10 00000d00 00000077",
                     {mem_write_o, overflow_o}, mem_addr_o, mem_data_o);
        end
        begin_cycle();
        mem_done_i = 1'b1;
        #1;
        $display("txn port=0 store addr=00000d00 done=%b", req0_done_o);
    endtask

    task automatic test_timeout();
        do_reset();
        begin_cycle();
        req0_read_i = 1'b1; req0_addr_i = 32'h0000_0E00;
        #1;
        begin_cycle(); #1;
        begin_cycle(); #1;
        n_checks++;
        if (mem_read_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_strobe: read got %b want 1", mem_read_o);
        end
        for (int k = 1; k <= MAX_WAIT; k++) begin
            begin_cycle();
            mem_rd_data_i = 32'hFFFF_0000;
            #1;
            n_checks++;
            if (k < MAX_WAIT) begin
                if (req0_done_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tmo_early wait%0d: done0 got %b want 0", k, req0_done_o);
                end
            end else if ({req0_done_o, timeout_o, req0_rd_data_o} !== {2'b10, 32'd0}) begin
                n_fail++;
                $display("FAIL tmo_abort: done0=%b timeout=%b data=%h want 1 0 0", req0_done_o, timeout_o, req0_rd_data_o);
            end
        end
        $display("txn port=0 load addr=00000e00 aborted");
        begin_cycle();
        #1;
        n_checks++;
        if ({timeout_o, busy_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL tmo_after: timeout/busy got %b want 10", {timeout_o, busy_o});
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        begin_cycle();
        req1_read_i = 1'b1; req1_addr_i = 32'h0000_0F00;
        #1;
        begin_cycle(); #1;
        begin_cycle(); #1;
        begin_cycle();
        #1;
        n_checks++;
        if ({busy_o, grant_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstw_busy: busy/grant got %b want 11", {busy_o, grant_o});
        end
        #1;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if ({busy_o, grant_o, mem_read_o, req1_done_o, timeout_o, overflow_o} !== 6'd0) begin
            n_fail++;
            $display("FAIL rstw_async: busy/grant/rd/done1/tmo/ovf got %b want 000000",
                     {busy_o, grant_o, mem_read_o, req1_done_o, timeout_o, overflow_o});
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        begin_cycle();
        mem_done_i    = 1'b1;
        mem_rd_data_i = 32'h1234_5678;
        #1;
        n_checks++;
        if ({req0_done_o, req1_done_o, req1_rd_data_o} !== 34'd0) begin
            n_fail++;
            $display("FAIL rstw_ignore: done0=%b done1=%b data=%h want 0 0 0", req0_done_o, req1_done_o, req1_rd_data_o);
        end
        begin_cycle(); #1;
        begin_cycle(); #1;
        n_checks++;
        if ({busy_o, mem_read_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstw_no_replay: busy/read got %b want 00", {busy_o, mem_read_o});
        end
    endtask

    // Reference model: an access is a timestamp (strobe cycle). Everything
    // else follows from the elapsed-cycle arithmetic and the pending slots.
    task automatic test_random();
        for (int seg = 0; seg < 3; seg++) begin
            bit          pv[2];
            bit          pop[2];
            logic [31:0] pa[2];
            logic [31:0] pd[2];
            bit          busy, ovf, tmo;
            int          owner, t_strobe, rr;
            do_reset();
            pv = '{0, 0}; pop = '{0, 0}; pa = '{0, 0}; pd = '{0, 0};
            busy = 0; ovf = 0; tmo = 0; owner = 0; t_strobe = 0; rr = 0;
            for (int c = 0; c < 500; c++) begin
                bit          rdp[2], wrp[2];
                logic [31:0] ai[2], di[2];
                logic [65:0] exp_mem;
                logic [65:0] exp_done;
                logic [3:0]  exp_stat;
                int          done_port;
                bit          timed_out;
                begin_cycle();
                for (int p = 0; p < 2; p++) begin
                    rdp[p] = ($urandom_range(0, 5) == 0);
                    wrp[p] = ($urandom_range(0, 5) == 0);
                    ai[p]  = $urandom();
                    di[p]  = $urandom();
                end
                req0_read_i = rdp[0]; req0_write_i = wrp[0]; req0_addr_i = ai[0]; req0_data_i = di[0];
                req1_read_i = rdp[1]; req1_write_i = wrp[1]; req1_addr_i = ai[1]; req1_data_i = di[1];
                mem_done_i    = ($urandom_range(0, 9) < 3);
                mem_rd_data_i = $urandom();
                #1;
                exp_mem   = '0;
                exp_done  = '0;
                done_port = -1;
                timed_out = 0;
                if (busy && c == t_strobe) begin
                    exp_mem = {!pop[owner], pop[owner], pa[owner], pd[owner]};
                end else if (busy && c > t_strobe) begin
                    if (mem_done_i) begin
                        done_port = owner;
                    end else if (c - t_strobe == MAX_WAIT) begin
                        done_port = owner;
                        timed_out = 1;
                    end
                end
                if (done_port == 0)
                    exp_done = {2'b10, (pop[0] || timed_out) ? 32'd0 : mem_rd_data_i, 32'd0};
                else if (done_port == 1)
                    exp_done = {2'b01, 32'd0, (pop[1] || timed_out) ? 32'd0 : mem_rd_data_i};
                exp_stat = {busy, ovf, tmo, busy ? owner[0] : 1'b0};
                n_checks++;
                if ({mem_read_o, mem_write_o, mem_addr_o, mem_data_o} !== exp_mem) begin
                    n_fail++;
                    $display("FAIL rand_mem s%0d c%0d: got %h want %h", seg, c,
                             {mem_read_o, mem_write_o, mem_addr_o, mem_data_o}, exp_mem);
                end
                n_checks++;
                if ({req0_done_o, req1_done_o, req0_rd_data_o, req1_rd_data_o} !== exp_done) begin
                    n_fail++;
                    $display("FAIL rand_done s%0d c%0d: got %h want %h", seg, c,
                             {req0_done_o, req1_done_o, req0_rd_data_o, req1_rd_data_o}, exp_done);
                end
                n_checks++;
                if ({busy_o, overflow_o, timeout_o, busy_o ? grant_o : 1'b0} !== exp_stat) begin
                    n_fail++;
                    $display("FAIL rand_status s%0d c%0d: busy/ovf/tmo/grant got %b want %b", seg, c,
                             {busy_o, overflow_o, timeout_o, busy_o ? grant_o : 1'b0}, exp_stat);
                end
                if (done_port >= 0)
                    $display("txn port=%0d %s addr=%h %s", done_port, pop[done_port] ? "store" : "load",
                             pa[done_port], timed_out ? "aborted" : "done");
                // Advance the model past this clock edge.
                if (!busy && (pv[0] || pv[1])) begin
                    owner    = (pv[0] && pv[1]) ? rr : (pv[0] ? 0 : 1);
                    busy     = 1;
                    t_strobe = c + 1;
                end else if (done_port >= 0) begin
                    busy      = 0;
                    rr        = 1 - owner;
                    pv[owner] = 0;
                    if (timed_out) tmo = 1;
                end
                for (int p = 0; p < 2; p++) begin
                    if (rdp[p] || wrp[p]) begin
                        if (pv[p]) begin
                            ovf = 1;
                        end else begin
                            pv[p]  = 1;
                            pop[p] = wrp[p];
                            pa[p]  = ai[p];
                            pd[p]  = di[p];
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_overflow();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
